// File: rtl/pattern_detector.sv
// Serial pattern detector with a loadable pattern register, overlapping or
// non-overlapping matching, and a saturating match counter.
module pattern_detector #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               seq,
   input  logic               pat_load,
   input  logic [PAT_LEN-1:0] pat_in,
   input  logic               cnt_clr,
   output logic               dout,
   output logic               armed,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cnt_sat
);

   localparam int FW = $clog2(PAT_LEN + 1);
   localparam logic [FW-1:0]      FILL_FULL = FW'(PAT_LEN);
   localparam logic [FW-1:0]      FILL_ONE  = {{(FW-1){1'b0}}, 1'b1};
   localparam logic [FW-1:0]      FILL_ZERO = {FW{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [PAT_LEN-1:0] HIST_ZERO = {PAT_LEN{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_ARMED = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PAT_LEN-1:0] r_pat;
   logic [PAT_LEN-1:0] r_hist;
   logic [FW-1:0]      r_fill;
   logic               r_dout;
   logic               r_armed;
   logic [CNT_W-1:0]   r_cnt;

   logic [PAT_LEN-1:0] w_hist_sh;
   logic [FW-1:0]      w_fill_inc;
   logic               w_hit;
   logic [PAT_LEN-1:0] w_pat_nxt;
   logic [PAT_LEN-1:0] w_hist_nxt;
   logic [FW-1:0]      w_fill_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_dout_nxt;
   logic               w_armed_nxt;

   // Sampling datapath: pattern load wins over enable; a detection compares
   // the history as it will be after this edge's shift.
   always_comb begin
      w_hist_sh  = {r_hist[PAT_LEN-2:0], seq};
      w_fill_inc = (r_fill == FILL_FULL) ? FILL_FULL : (r_fill + FILL_ONE);
      w_hit      = 1'b0;
      w_pat_nxt  = r_pat;
      w_hist_nxt = r_hist;
      w_fill_nxt = r_fill;
      if (pat_load) begin
         w_pat_nxt  = pat_in;
         w_hist_nxt = HIST_ZERO;
         w_fill_nxt = FILL_ZERO;
      end else if (en) begin
         w_hist_nxt = w_hist_sh;
         w_hit      = (w_hist_sh == r_pat) && (w_fill_inc == FILL_FULL);
         if (w_hit && !OVERLAP) begin
            w_fill_nxt = FILL_ZERO;
         end else begin
            w_fill_nxt = w_fill_inc;
         end
      end else begin
         w_hist_nxt = r_hist;
         w_fill_nxt = r_fill;
      end
   end

   // Match counter: a clear coinciding with a detection leaves a count of one.
   always_comb begin
      case ({w_hit, cnt_clr})
         2'b11:   w_cnt_nxt = CNT_ONE;
         2'b01:   w_cnt_nxt = CNT_ZERO;
         2'b10:   w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   // Next state follows the post-edge fill level.
   always_comb begin
      if (w_fill_nxt == FILL_ZERO) begin
         w_state_nxt = ST_IDLE;
      end else if (w_fill_nxt == FILL_FULL) begin
         w_state_nxt = ST_ARMED;
      end else begin
         w_state_nxt = ST_FILL;
      end
   end

   always_comb begin
      w_dout_nxt = w_hit;
      case (w_state_nxt)
         ST_ARMED: w_armed_nxt = 1'b1;
         ST_IDLE:  w_armed_nxt = 1'b0;
         ST_FILL:  w_armed_nxt = 1'b0;
         default:  w_armed_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pat   <= PATTERN;
         r_hist  <= HIST_ZERO;
         r_fill  <= FILL_ZERO;
         r_dout  <= 1'b0;
         r_armed <= 1'b0;
         r_cnt   <= CNT_ZERO;
      end else begin
         r_pat   <= w_pat_nxt;
         r_hist  <= w_hist_nxt;
         r_fill  <= w_fill_nxt;
         r_dout  <= w_dout_nxt;
         r_armed <= w_armed_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign dout      = r_dout;
   assign armed     = r_armed;
   assign match_cnt = r_cnt;
   assign cnt_sat   = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector: three configurations driven in lockstep and
// checked against a bit-stream reference model plus directed expectations.
module tb_pattern_detector;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       seq = 1'b0;
   logic       pat_load = 1'b0;
   logic [3:0] pat_in = 4'd0;
   logic       cnt_clr = 1'b0;

   logic       d [3];
   logic       a [3];
   logic       s [3];
   logic [7:0] c0, c1;
   logic [1:0] c2;
   logic [10:0] obs_v [3];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: bits seen since the last clear and their running value.
   int m_len [3];
   int m_hist [3];
   int m_cnt [3];
   bit m_dout [3];
   int m_pat;

   always #5 clk = ~clk;

   pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
      .clk(clk), .rst(rst), .en(en), .seq(seq), .pat_load(pat_load), .pat_in(pat_in),
      .cnt_clr(cnt_clr), .dout(d[0]), .armed(a[0]), .match_cnt(c0), .cnt_sat(s[0]));
   pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
      .clk(clk), .rst(rst), .en(en), .seq(seq), .pat_load(pat_load), .pat_in(pat_in),
      .cnt_clr(cnt_clr), .dout(d[1]), .armed(a[1]), .match_cnt(c1), .cnt_sat(s[1]));
   pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
      .clk(clk), .rst(rst), .en(en), .seq(seq), .pat_load(pat_load), .pat_in(pat_in),
      .cnt_clr(cnt_clr), .dout(d[2]), .armed(a[2]), .match_cnt(c2), .cnt_sat(s[2]));

   always_comb begin
      obs_v[0] = {d[0], a[0], s[0], c0};
      obs_v[1] = {d[1], a[1], s[1], c1};
      obs_v[2] = {d[2], a[2], s[2], 6'd0, c2};
   end

   function automatic bit ov(int k);
      return k != 1;
   endfunction

   function automatic int cmax(int k);
      return (k == 2) ? 3 : 255;
   endfunction

   function automatic logic [10:0] exp_vec(int k);
      logic [7:0] cv;
      cv = 8'(m_cnt[k]);
      return {m_dout[k], (m_len[k] >= 4), (m_cnt[k] == cmax(k)), cv};
   endfunction

   function automatic void model_reset();
      m_pat = 11;
      for (int k = 0; k < 3; k++) begin
         m_len[k] = 0; m_hist[k] = 0; m_cnt[k] = 0; m_dout[k] = 1'b0;
      end
   endfunction

   // Drive one edge's inputs, advance the model, then sample after the edge.
   task automatic tick(input bit e, input bit sb, input bit ld, input logic [3:0] pin, input bit clr);
      bit hit;
      en = e; seq = sb; pat_load = ld; pat_in = pin; cnt_clr = clr;
      for (int k = 0; k < 3; k++) begin
         hit = 1'b0;
         if (ld) begin
            m_len[k] = 0; m_hist[k] = 0;
         end else if (e) begin
            m_hist[k] = (m_hist[k] * 2 + int'(sb)) % 16;
            m_len[k]  = m_len[k] + 1;
            hit = (m_len[k] >= 4) && (m_hist[k] == m_pat);
            if (hit && !ov(k)) m_len[k] = 0;
         end
         m_dout[k] = hit;
         if (clr) m_cnt[k] = hit ? 1 : 0;
         else if (hit && m_cnt[k] < cmax(k)) m_cnt[k] = m_cnt[k] + 1;
      end
      if (ld) m_pat = int'(pin);
      @(posedge clk);
      #1;
      en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (obs_v[k] !== 11'd0) begin
            n_fail++; $display("FAIL reset_state inst%0d: got %h want %h", k, obs_v[k], 11'd0);
         end
      end
      en = 1'b1; seq = 1'b1; pat_load = 1'b1; pat_in = 4'b1111; cnt_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (obs_v[k] !== 11'd0) begin
            n_fail++; $display("FAIL reset_ignores_inputs inst%0d: got %h want %h", k, obs_v[k], 11'd0);
         end
      end
      en = 1'b0; pat_load = 1'b0; seq = 1'b0;
      #2 rst = 1'b0;
      model_reset();
      // Default pattern must be live right after reset.
      tick(1, 1, 0, 4'd0, 0); tick(1, 0, 0, 4'd0, 0); tick(1, 1, 0, 4'd0, 0); tick(1, 1, 0, 4'd0, 0);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (obs_v[k] !== exp_vec(k)) begin
            n_fail++; $display("FAIL reset_default_pattern inst%0d: got %h want %h", k, obs_v[k], exp_vec(k));
         end
      end
   endtask

   task automatic test_overlap();
      bit stream [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      bit ov_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      bit no_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tick(0, 0, 1, 4'b1011, 1);
      for (int i = 0; i < 7; i++) begin
         tick(1, stream[i], 0, 4'd0, 0);
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_v[k] !== exp_vec(k)) begin
               n_fail++; $display("FAIL overlap_model edge%0d inst%0d: got %h want %h", i + 1, k, obs_v[k], exp_vec(k));
            end
         end
         n_tests++;
         if (d[0] !== ov_exp[i] || d[1] !== no_exp[i] || a[1] !== 1'b0) begin
            n_fail++; $display("FAIL overlap_pulses edge%0d: got ov=%b no=%b no_armed=%b want %b %b 0",
                               i + 1, d[0], d[1], a[1], ov_exp[i], no_exp[i]);
         end
      end
      n_tests++;
      if (c0 !== 8'd2 || c1 !== 8'd1) begin
         n_fail++; $display("FAIL overlap_counts: got %0d/%0d want 2/1", c0, c1);
      end
   endtask

   task automatic test_gap();
      tick(0, 0, 1, 4'b1011, 1);
      tick(1, 1, 0, 4'd0, 0);
      tick(1, 0, 0, 4'd0, 0);
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0, 4'd0, 0);
         n_tests++;
         if (a[0] !== 1'b0 || d[0] !== 1'b0 || d[1] !== 1'b0) begin
            n_fail++; $display("FAIL gap_hold cycle%0d: got armed=%b dout=%b/%b want 0 0/0", i, a[0], d[0], d[1]);
         end
      end
      tick(1, 1, 0, 4'd0, 0);
      n_tests++;
      if (d[0] !== 1'b0) begin
         n_fail++; $display("FAIL gap_early_pulse: got %b want 0", d[0]);
      end
      tick(1, 1, 0, 4'd0, 0);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (obs_v[k] !== exp_vec(k) || d[k] !== 1'b1) begin
            n_fail++; $display("FAIL gap_final inst%0d: got %h want %h", k, obs_v[k], exp_vec(k));
         end
      end
   endtask

   task automatic test_pat_load();
      bit stream [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      int pulses = 0;
      tick(0, 0, 1, 4'b0110, 1);
      for (int i = 0; i < 8; i++) begin
         tick(1, stream[i], 0, 4'd0, 0);
         if (d[0] === 1'b1) pulses++;
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_v[k] !== exp_vec(k)) begin
               n_fail++; $display("FAIL pat_load_model edge%0d inst%0d: got %h want %h", i + 1, k, obs_v[k], exp_vec(k));
            end
         end
      end
      n_tests++;
      if (pulses != 1 || c0 !== 8'd1) begin
         n_fail++; $display("FAIL pat_load_count: got pulses=%0d cnt=%0d want 1 1", pulses, c0);
      end
   endtask

   task automatic test_saturate();
      bit stream [13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      tick(0, 0, 1, 4'b1011, 1);
      for (int i = 0; i < 13; i++) begin
         tick(1, stream[i], 0, 4'd0, 0);
         n_tests++;
         if (obs_v[2] !== exp_vec(2)) begin
            n_fail++; $display("FAIL sat_model edge%0d: got %h want %h", i + 1, obs_v[2], exp_vec(2));
         end
      end
      n_tests++;
      if (c2 !== 2'd3 || s[2] !== 1'b1 || c0 !== 8'd4 || s[0] !== 1'b0) begin
         n_fail++; $display("FAIL sat_reached: got c2=%0d sat=%b c0=%0d sat0=%b want 3 1 4 0", c2, s[2], c0, s[0]);
      end
      tick(1, 0, 0, 4'd0, 0);
      tick(1, 1, 0, 4'd0, 0);
      tick(1, 1, 0, 4'd0, 1);
      n_tests++;
      if (d[2] !== 1'b1 || c2 !== 2'd1 || s[2] !== 1'b0 || c0 !== 8'd1) begin
         n_fail++; $display("FAIL sat_clr_with_hit: got d=%b c2=%0d sat=%b c0=%0d want 1 1 0 1", d[2], c2, s[2], c0);
      end
   endtask

   task automatic test_reset_mid();
      bit pre [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bit post [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      bit post_exp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tick(0, 0, 1, 4'b0110, 1);
      for (int i = 0; i < 7; i++) tick(1, pre[i], 0, 4'd0, 0);
      n_tests++;
      if (c0 !== 8'd1 || a[0] !== 1'b1) begin
         n_fail++; $display("FAIL mid_preamble: got cnt=%0d armed=%b want 1 1", c0, a[0]);
      end
      #3 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (obs_v[k] !== 11'd0) begin
            n_fail++; $display("FAIL mid_async_reset inst%0d: got %h want %h", k, obs_v[k], 11'd0);
         end
      end
      #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         tick(1, post[i], 0, 4'd0, 0);
         n_tests++;
         if (d[0] !== post_exp[i] || d[1] !== post_exp[i] || obs_v[0] !== exp_vec(0)) begin
            n_fail++; $display("FAIL mid_post_reset edge%0d: got d=%b/%b v=%h want %b v=%h",
                               i + 1, d[0], d[1], obs_v[0], post_exp[i], exp_vec(0));
         end
      end
   endtask

   task automatic test_random();
      bit e, sb, ld, clr;
      logic [3:0] pin;
      for (int i = 0; i < 600; i++) begin
         e   = ($urandom_range(0, 9) < 8);
         sb  = 1'($urandom_range(0, 1));
         ld  = ($urandom_range(0, 49) == 0);
         clr = ($urandom_range(0, 39) == 0);
         pin = ($urandom_range(0, 1) == 0) ? 4'b1011 : 4'($urandom_range(0, 15));
         tick(e, sb, ld, pin, clr);
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_v[k] !== exp_vec(k)) begin
               n_fail++; $display("FAIL random cyc%0d inst%0d: got %h want %h", i, k, obs_v[k], exp_vec(k));
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_overlap();
      test_gap();
      test_pat_load();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
